ram_port_arbiter: RTL and testbench
===================================

// Module: ram_port_arbiter
// PURPOSE
// - Shares the single-port data RAM between the CPU datapath and a debug/loader requester (UART side).
// - The CPU (CU-driven RAM_in/RAM_out, AR address, BUS data) has priority.
// - The debug port gets a guaranteed slot after at most MAX_WAIT consecutive CPU-held cycles; the CPU is stalled for that cycle.
// - Sits between the CPU's RAM strobes and the ram instance; the CU/SC freeze on cpu_stall.
// PARAMETERS
// - AW        8  RAM address width
// - DW        8  RAM data width
// - MAX_WAIT  4  max consecutive cycles dbg_req may lose to the CPU before forced grant (>=1)
// PORTS
// - clk        in   1   rising-edge clock
// - reset      in   1   asynchronous, active-high reset
// - cpu_we     in   1   CPU write strobe (RAM_in)
// - cpu_re     in   1   CPU read strobe (RAM_out)
// - cpu_addr   in   AW  CPU address (AR direct output)
// - cpu_wdata  in   DW  CPU write data (BUS)
// - cpu_rdata  out  DW  CPU read data; valid the cycle after an accepted cpu_re
// - cpu_stall  out  1   CPU access not accepted this cycle; CU must hold step/strobes
// - dbg_req    in   1   debug request; held high until dbg_gnt
// - dbg_we     in   1   1=write, 0=read; sampled with dbg_req
// - dbg_addr   in   AW  debug address
// - dbg_wdata  in   DW  debug write data
// - dbg_gnt    out  1   1-cycle pulse: debug access issued to RAM this cycle
// - dbg_rdata  out  DW  debug read data, registered
// - dbg_valid  out  1   1-cycle pulse the cycle after a granted debug read
// - ram_we     out  1   to ram.we
// - ram_re     out  1   to ram.re
// - ram_addr   out  AW  to ram.addr
// - ram_wdata  out  DW  to ram.data_in
// - ram_rdata  in   DW  from ram; valid 1 cycle after ram_re
// BEHAVIOUR
// - Reset (async): dbg_gnt=0, dbg_valid=0, dbg_rdata=0, wait_cnt=0, owner=CPU, rsp_pend=NONE.
//   Combinational outputs then follow CPU inputs; cpu_stall=0.
// - Per-cycle grant decision (combinational on registered wait_cnt):
//   - cpu_act = cpu_we|cpu_re.
//     - cpu_we & cpu_re together is illegal; treat as a write, read suppressed.
//   - force = dbg_req & (wait_cnt==MAX_WAIT).
//   - grant_dbg = dbg_req & (~cpu_act | force).
//   - grant_dbg=1: RAM port driven by dbg_*; dbg_gnt=1; cpu_stall=cpu_act.
//   - else: RAM port driven by cpu_*, passed straight through; cpu_stall=0.
//   - Idle: ram_we=ram_re=0; addr/wdata follow the CPU.
// - wait_cnt:
//   - increments when dbg_req & ~grant_dbg, saturating at MAX_WAIT.
//   - clears on grant_dbg or when dbg_req=0.
// - Read response pipeline:
//   - rsp_pend register records who issued ram_re (NONE/CPU/DBG).
//   - Next cycle, if DBG: dbg_rdata<=ram_rdata, then dbg_valid pulses.
//   - cpu_rdata = ram_rdata combinationally; meaningful only in the cycle after an accepted CPU read.
//   - The CU's existing 1-cycle read timing is preserved.
// - Back-to-back debug grants are allowed when the CPU is idle; each cycle is a separate access.
// - Debug write latency: 0 (written on the grant edge).
// - Debug read latency: dbg_gnt at cycle N, dbg_valid at N+1.
// - Stalled CPU access: must be presented unchanged the next cycle; it is guaranteed to win then.
//   - Reason: wait_cnt is cleared by the forced grant.
//   - Max CPU stall is 1 cycle per MAX_WAIT+1.
// - dbg_req dropped without a grant: no access; the counter clears.
// - Reset mid-read: the pending response is discarded; dbg_valid does not pulse.
// STRUCTURE
// - Shared package, cpu_pkg:
//   - localparams RAM_AW=8, RAM_DW=8.
//   - enum owner_t {OWN_NONE, OWN_CPU, OWN_DBG} (2 bits), also used by the CU for debug tracing.
// - Single module, no sub-module.
//   - The grant mux plus saturating counter is ~150 lines.
//   - Keep the counter inline.
// TESTING
// - CPU-only traffic:
//   - Write 0x5A@0x10, then read 0x10.
//   - Expect ram_we/addr passthrough, cpu_rdata=0x5A next cycle, cpu_stall=0 throughout.
// - Debug-only:
//   - dbg write 0xC3@0x20, then dbg read 0x20.
//   - Expect dbg_gnt on each request cycle; dbg_valid one cycle after the read gnt, with dbg_rdata=0xC3.
// - Contention, MAX_WAIT=4:
//   - cpu_re held every cycle, dbg_req held.
//   - Expect dbg_gnt on the 5th cycle, cpu_stall=1 only that cycle, then CPU wins the next cycle.
// - Simultaneous start:
//   - dbg_req rises with the CPU idle and cpu_we rising the next cycle.
//   - Expect dbg granted cycle 0; CPU granted cycle 1, no stall.
// - Reset mid-operation:
//   - Assert reset one cycle after a dbg read grant.
//   - Expect dbg_valid=0, dbg_rdata=0, wait_cnt=0 immediately (async).
// - Abandoned request:
//   - dbg_req high 2 cycles under CPU traffic, then low.
//   - Expect no dbg_gnt; a later request waits a full MAX_WAIT again.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU-side definitions: RAM geometry and the RAM port owner encoding,
// which the CU also uses for debug tracing.
package cpu_pkg;

  localparam int RAM_AW = 8;
  localparam int RAM_DW = 8;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_DBG  = 2'd2
  } owner_t;

endpackage

// File: rtl/ram_port_arbiter.sv
// Shares the single-port data RAM between the CPU datapath (priority) and a
// debug/loader port that is force-granted after MAX_WAIT consecutive losses.
module ram_port_arbiter
  import cpu_pkg::*;
#(
  parameter int AW       = RAM_AW,
  parameter int DW       = RAM_DW,
  parameter int MAX_WAIT = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_we,
  input  logic          cpu_re,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_stall,
  input  logic          dbg_req,
  input  logic          dbg_we,
  input  logic [AW-1:0] dbg_addr,
  input  logic [DW-1:0] dbg_wdata,
  output logic          dbg_gnt,
  output logic [DW-1:0] dbg_rdata,
  output logic          dbg_valid,
  output logic          ram_we,
  output logic          ram_re,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata
);

  localparam int             CW      = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0]  MAX_CNT = CW'(MAX_WAIT);

  logic [CW-1:0] r_wait_cnt;
  owner_t        r_rsp_pend;
  logic [DW-1:0] r_dbg_rdata;

  logic          w_cpu_act;
  logic          w_cpu_rd;
  logic          w_force;
  logic          w_grant_dbg;
  owner_t        w_owner;
  owner_t        w_rsp_nxt;
  logic          w_ram_we;
  logic          w_ram_re;
  logic [CW-1:0] w_wait_nxt;

  // Grant decision and RAM port mux; a simultaneous CPU we/re is a write.
  always_comb begin
    w_cpu_act   = cpu_we | cpu_re;
    w_cpu_rd    = cpu_re & ~cpu_we;
    w_force     = dbg_req & (r_wait_cnt == MAX_CNT);
    w_grant_dbg = dbg_req & (~w_cpu_act | w_force);
    w_owner     = w_grant_dbg ? OWN_DBG : OWN_CPU;

    w_ram_we  = cpu_we;
    w_ram_re  = w_cpu_rd;
    ram_addr  = cpu_addr;
    ram_wdata = cpu_wdata;
    if (w_owner == OWN_DBG) begin
      w_ram_we  = dbg_we;
      w_ram_re  = ~dbg_we;
      ram_addr  = dbg_addr;
      ram_wdata = dbg_wdata;
    end

    w_rsp_nxt = w_ram_re ? w_owner : OWN_NONE;

    w_wait_nxt = r_wait_cnt;
    if (!dbg_req || w_grant_dbg) begin
      w_wait_nxt = '0;
    end else if (r_wait_cnt != MAX_CNT) begin
      w_wait_nxt = r_wait_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wait_cnt  <= '0;
      r_rsp_pend  <= OWN_NONE;
      r_dbg_rdata <= '0;
    end else begin
      r_wait_cnt <= w_wait_nxt;
      r_rsp_pend <= w_rsp_nxt;
      if (r_rsp_pend == OWN_DBG) begin
        r_dbg_rdata <= ram_rdata;
      end
    end
  end

  assign ram_we    = w_ram_we;
  assign ram_re    = w_ram_re;
  assign dbg_gnt   = w_grant_dbg;
  assign cpu_stall = w_grant_dbg & w_cpu_act;
  assign cpu_rdata = ram_rdata;

  // Read data is shown live in the response cycle so dbg_valid and its data
  // coincide one cycle after the grant, then held from the capture register.
  assign dbg_valid = (r_rsp_pend == OWN_DBG);
  assign dbg_rdata = dbg_valid ? ram_rdata : r_dbg_rdata;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: vector table plus hand sequences, read data
// checked through a scoreboard against a shadow of every expected RAM write.
module tb_ram_port_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       cpu_we, cpu_re;
  logic [7:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic       cpu_stall;
  logic       dbg_req, dbg_we;
  logic [7:0] dbg_addr, dbg_wdata, dbg_rdata;
  logic       dbg_gnt, dbg_valid;
  logic       ram_we, ram_re;
  logic [7:0] ram_addr, ram_wdata, ram_rdata;

  ram_port_arbiter #(.AW(8), .DW(8), .MAX_WAIT(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .cpu_we    (cpu_we),
    .cpu_re    (cpu_re),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_stall (cpu_stall),
    .dbg_req   (dbg_req),
    .dbg_we    (dbg_we),
    .dbg_addr  (dbg_addr),
    .dbg_wdata (dbg_wdata),
    .dbg_gnt   (dbg_gnt),
    .dbg_rdata (dbg_rdata),
    .dbg_valid (dbg_valid),
    .ram_we    (ram_we),
    .ram_re    (ram_re),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata)
  );

  always #5 clk = ~clk;

  // Single-port RAM with a registered read, as the real ram instance behaves.
  logic [7:0] mem [256];
  always_ff @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    if (ram_re) ram_rdata <= mem[ram_addr];
  end

  typedef struct {
    logic       cwe, cre;
    logic [7:0] caddr, cwd;
    logic       dreq, dwe;
    logic [7:0] daddr, dwd;
    logic       egnt, estall, ewe, ere;
    logic [7:0] eaddr, ewd;
  } vec_t;

  typedef struct {
    bit         dbg;
    logic [7:0] data;
  } rsp_t;

  rsp_t       sb[$];
  logic [7:0] shadow [256];
  int         n_chk = 0;
  int         n_err = 0;

  function automatic vec_t mk(input logic cwe, cre, input logic [7:0] caddr, cwd,
                              input logic dreq, dwe, input logic [7:0] daddr, dwd,
                              input logic egnt, estall, ewe, ere,
                              input logic [7:0] eaddr, ewd);
    vec_t v;
    v.cwe = cwe;   v.cre = cre;     v.caddr = caddr; v.cwd = cwd;
    v.dreq = dreq; v.dwe = dwe;     v.daddr = daddr; v.dwd = dwd;
    v.egnt = egnt; v.estall = estall; v.ewe = ewe;   v.ere = ere;
    v.eaddr = eaddr; v.ewd = ewd;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive_idle();
    cpu_we = 0; cpu_re = 0; cpu_addr = 8'h00; cpu_wdata = 8'h00;
    dbg_req = 0; dbg_we = 0; dbg_addr = 8'h00; dbg_wdata = 8'h00;
  endtask

  // Called 1 time unit after a rising edge; checks mid-cycle and returns at the next edge + 1.
  task automatic apply(input vec_t v);
    rsp_t e;
    cpu_we = v.cwe;   cpu_re = v.cre;   cpu_addr = v.caddr; cpu_wdata = v.cwd;
    dbg_req = v.dreq; dbg_we = v.dwe;   dbg_addr = v.daddr; dbg_wdata = v.dwd;
    #3;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("dbg_valid", {31'd0, dbg_valid}, {31'd0, e.dbg});
      if (e.dbg) chk("dbg_rdata", {24'd0, dbg_rdata}, {24'd0, e.data});
      else       chk("cpu_rdata", {24'd0, cpu_rdata}, {24'd0, e.data});
    end else begin
      chk("dbg_valid_idle", {31'd0, dbg_valid}, 32'd0);
    end
    chk("dbg_gnt",   {31'd0, dbg_gnt},   {31'd0, v.egnt});
    chk("cpu_stall", {31'd0, cpu_stall}, {31'd0, v.estall});
    chk("ram_we",    {31'd0, ram_we},    {31'd0, v.ewe});
    chk("ram_re",    {31'd0, ram_re},    {31'd0, v.ere});
    chk("ram_addr",  {24'd0, ram_addr},  {24'd0, v.eaddr});
    chk("ram_wdata", {24'd0, ram_wdata}, {24'd0, v.ewd});
    if (v.ere) begin
      e.dbg  = v.egnt;
      e.data = shadow[v.eaddr];
      sb.push_back(e);
    end
    if (v.ewe) shadow[v.eaddr] = v.ewd;
    @(posedge clk);
    #1;
  endtask

  // CPU reads 0x10 every cycle while the debug port requests a read of 0x20.
  task automatic run_contend(input int n, input bit grant_last);
    bit g;
    for (int i = 0; i < n; i++) begin
      g = grant_last && (i == n - 1);
      apply(mk(0, 1, 8'h10, 8'h00, 1, 0, 8'h20, 8'h00,
               g, g, 0, 1, g ? 8'h20 : 8'h10, 8'h00));
    end
  endtask

  task automatic pulse_reset();
    drive_idle();
    reset = 1'b1;
    sb.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  vec_t tbl[$];

  initial begin
    drive_idle();
    reset = 1'b1;
    #2;
    chk("rst_dbg_gnt",   {31'd0, dbg_gnt},   32'd0);
    chk("rst_dbg_valid", {31'd0, dbg_valid}, 32'd0);
    chk("rst_dbg_rdata", {24'd0, dbg_rdata}, 32'd0);
    chk("rst_cpu_stall", {31'd0, cpu_stall}, 32'd0);
    cpu_we = 1; cpu_addr = 8'h77; cpu_wdata = 8'h66;
    #1;
    chk("rst_ram_we_pass",   {31'd0, ram_we},   32'd1);
    chk("rst_ram_addr_pass", {24'd0, ram_addr}, 32'h77);
    chk("rst_ram_wd_pass",   {24'd0, ram_wdata}, 32'h66);
    drive_idle();
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;

    //            cwe cre caddr  cwd   dreq dwe daddr  dwd    gnt stl we re eaddr  ewd
    tbl.push_back(mk(1, 0, 8'h10, 8'h5A, 0, 0, 8'h00, 8'h00, 0, 0, 1, 0, 8'h10, 8'h5A));
    tbl.push_back(mk(0, 1, 8'h10, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 0, 1, 8'h10, 8'h00));
    tbl.push_back(mk(0, 0, 8'h33, 8'h44, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0, 8'h33, 8'h44));
    tbl.push_back(mk(0, 0, 8'h00, 8'h00, 1, 1, 8'h20, 8'hC3, 1, 0, 1, 0, 8'h20, 8'hC3));
    tbl.push_back(mk(0, 0, 8'h00, 8'h00, 1, 0, 8'h20, 8'h00, 1, 0, 0, 1, 8'h20, 8'h00));
    tbl.push_back(mk(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0, 8'h00, 8'h00));
    tbl.push_back(mk(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0, 8'h00, 8'h00));
    tbl.push_back(mk(0, 0, 8'h00, 8'h00, 1, 0, 8'h10, 8'h00, 1, 0, 0, 1, 8'h10, 8'h00));
    tbl.push_back(mk(0, 0, 8'h00, 8'h00, 1, 0, 8'h20, 8'h00, 1, 0, 0, 1, 8'h20, 8'h00));
    tbl.push_back(mk(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0, 8'h00, 8'h00));
    tbl.push_back(mk(0, 0, 8'h00, 8'h00, 1, 1, 8'h30, 8'h77, 1, 0, 1, 0, 8'h30, 8'h77));
    tbl.push_back(mk(1, 0, 8'h31, 8'h11, 0, 0, 8'h00, 8'h00, 0, 0, 1, 0, 8'h31, 8'h11));
    tbl.push_back(mk(1, 1, 8'h40, 8'h99, 0, 0, 8'h00, 8'h00, 0, 0, 1, 0, 8'h40, 8'h99));
    tbl.push_back(mk(0, 1, 8'h40, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 0, 1, 8'h40, 8'h00));
    tbl.push_back(mk(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0, 8'h00, 8'h00));
    foreach (tbl[i]) apply(tbl[i]);

    // Contention: forced grant on the 5th cycle, CPU wins the cycle after.
    run_contend(5, 1'b1);
    apply(mk(0, 1, 8'h10, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 0, 1, 8'h10, 8'h00));
    apply(mk(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0, 8'h00, 8'h00));

    // Abandoned request: the counter must restart from zero.
    run_contend(2, 1'b0);
    apply(mk(0, 1, 8'h10, 8'h00, 0, 0, 8'h20, 8'h00, 0, 0, 0, 1, 8'h10, 8'h00));
    run_contend(5, 1'b1);
    apply(mk(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0, 8'h00, 8'h00));

    // Reset one cycle after a debug read grant discards the response.
    apply(mk(0, 0, 8'h00, 8'h00, 1, 0, 8'h20, 8'h00, 1, 0, 0, 1, 8'h20, 8'h00));
    drive_idle();
    reset = 1'b1;
    #1;
    chk("midrst_dbg_valid", {31'd0, dbg_valid}, 32'd0);
    chk("midrst_dbg_rdata", {24'd0, dbg_rdata}, 32'd0);
    chk("midrst_dbg_gnt",   {31'd0, dbg_gnt},   32'd0);
    sb.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;
    apply(mk(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0, 8'h00, 8'h00));

    // Reset clears a partially built wait count.
    run_contend(2, 1'b0);
    pulse_reset();
    run_contend(5, 1'b1);
    apply(mk(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0, 8'h00, 8'h00));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
